// File: rtl/present_pkg.sv
// Shared constants, S-box table and FSM state type for the PRESENT key-schedule controller.
package present_pkg;

    localparam int unsigned KEY_SIZE_80  = 80;
    localparam int unsigned KEY_SIZE_128 = 128;
    localparam int unsigned NUM_ROUNDS   = 31;
    localparam int unsigned RK_WIDTH     = 64;
    localparam int unsigned IDX_W        = 5;
    localparam int unsigned CNT_W        = 5;

    localparam logic [3:0] SBOX [16] = '{
        4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
        4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
    };

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } ks_state_e;

    function automatic logic [3:0] sbox4(input logic [3:0] x);
        return SBOX[x];
    endfunction

endpackage

// File: rtl/present_key_update.sv
// Combinational PRESENT key-register update: rotate left 61, S-box the top nibble(s),
// XOR the round counter into the size-specific bit field.
module present_key_update #(
    parameter int unsigned KEY_SIZE = present_pkg::KEY_SIZE_80
) (
    input  logic [KEY_SIZE-1:0]           key,
    input  logic [present_pkg::CNT_W-1:0] counter,
    output logic [KEY_SIZE-1:0]           key_next_c
);
    import present_pkg::*;

    logic [KEY_SIZE-1:0] rotated;

    assign rotated = {key[KEY_SIZE-62:0], key[KEY_SIZE-1:KEY_SIZE-61]};

    generate
        if (KEY_SIZE == KEY_SIZE_128) begin : g_k128
            always_comb begin
                key_next_c          = rotated;
                key_next_c[127:124] = sbox4(rotated[127:124]);
                key_next_c[123:120] = sbox4(rotated[123:120]);
                key_next_c[66:62]   = rotated[66:62] ^ counter;
            end
        end else begin : g_k80
            always_comb begin
                key_next_c        = rotated;
                key_next_c[79:76] = sbox4(rotated[79:76]);
                key_next_c[19:15] = rotated[19:15] ^ counter;
            end
        end
    endgenerate

endmodule

// File: rtl/present_key_sched_ctrl.sv
// PRESENT key-schedule controller: latches a master key and streams round keys
// K1..K(NUM_ROUNDS+1) over a valid/ready handshake, one key-register update per transfer.
module present_key_sched_ctrl #(
    parameter int unsigned KEY_SIZE   = present_pkg::KEY_SIZE_80,
    parameter int unsigned NUM_ROUNDS = present_pkg::NUM_ROUNDS
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [KEY_SIZE-1:0]              key_in,
    input  logic                             abort,
    output logic                             busy,
    output logic                             rk_valid,
    input  logic                             rk_ready,
    output logic [present_pkg::RK_WIDTH-1:0] rk_data,
    output logic [present_pkg::IDX_W-1:0]    rk_index,
    output logic                             done
);
    import present_pkg::*;

    ks_state_e           state_q, state_d;
    logic [KEY_SIZE-1:0] key_q, key_d, key_upd;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0]    round_cnt;
    logic                done_q, done_d;
    logic                valid_q;
    logic                last_round;

    // Counter for the key that follows the current one (idx+1, 5-bit wrap).
    assign round_cnt  = CNT_W'(idx_q + IDX_W'(1));
    assign last_round = (idx_q == IDX_W'(NUM_ROUNDS));

    present_key_update #(
        .KEY_SIZE (KEY_SIZE)
    ) u_key_update (
        .key        (key_q),
        .counter    (round_cnt),
        .key_next_c (key_upd)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus key/index/done updates; abort outranks a same-cycle transfer.
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    key_d   = key_in;
                    idx_d   = '0;
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (abort) begin
                    key_d   = '0;
                    idx_d   = '0;
                    state_d = ST_IDLE;
                end else if (rk_ready) begin
                    if (last_round) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        key_d = key_upd;
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_q   <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            key_q   <= key_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            valid_q <= (state_d == ST_STREAM);
        end
    end

    // All handshake outputs come straight from flops; rk_ready never reaches them combinationally.
    assign busy     = valid_q;
    assign rk_valid = valid_q;
    assign rk_data  = key_q[KEY_SIZE-1 -: RK_WIDTH];
    assign rk_index = idx_q;
    assign done     = done_q;

endmodule

// File: tb/tb_present_key_sched_ctrl.sv
// Scoreboard bench for present_key_sched_ctrl: 80-bit and 128-bit instances run in lockstep
// against a software key-schedule model, with random keys and random backpressure.
module tb_present_key_sched_ctrl;

    localparam int NR    = 31;
    localparam int NKEYS = NR + 1;

    localparam logic [3:0] SBOX_TB [16] = '{
        4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
        4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
    };
    localparam logic [63:0] ZK80 [3] = '{64'h0000000000000000, 64'hC000000000000000, 64'h5000180000000001};

    typedef struct packed {
        logic [4:0]  idx;
        logic [63:0] data;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst, start, abort, rk_ready;
    logic [127:0] key_in;

    logic         busy80, valid80, done80;
    logic [63:0]  data80;
    logic [4:0]   index80;
    logic         busy128, valid128, done128;
    logic [63:0]  data128;
    logic [4:0]   index128;

    exp_t q80[$];
    exp_t q128[$];

    int n_cmp = 0;
    int n_bad = 0;
    int exp_done = 0;
    int done_seen [2] = '{0, 0};
    int last_idx [2]  = '{-1, -1};
    bit prev_stall [2] = '{1'b0, 1'b0};
    logic [63:0] prev_data [2];
    logic [4:0]  prev_idx [2];

    always #5 clk = ~clk;

    present_key_sched_ctrl #(.KEY_SIZE(80), .NUM_ROUNDS(NR)) dut80 (
        .clk(clk), .rst(rst), .start(start), .key_in(key_in[79:0]), .abort(abort),
        .busy(busy80), .rk_valid(valid80), .rk_ready(rk_ready),
        .rk_data(data80), .rk_index(index80), .done(done80)
    );

    present_key_sched_ctrl #(.KEY_SIZE(128), .NUM_ROUNDS(NR)) dut128 (
        .clk(clk), .rst(rst), .start(start), .key_in(key_in), .abort(abort),
        .busy(busy128), .rk_valid(valid128), .rk_ready(rk_ready),
        .rk_data(data128), .rk_index(index128), .done(done128)
    );

    // Software key schedule: round key n (0-based) after n register updates.
    function automatic logic [63:0] ref_rk80(input logic [79:0] k0, input int n);
        logic [79:0] k = k0;
        for (int r = 1; r <= n; r++) begin
            k = (k << 61) | (k >> 19);
            k[79:76] = SBOX_TB[k[79:76]];
            k[19:15] = k[19:15] ^ 5'(r);
        end
        return k[79:16];
    endfunction

    function automatic logic [63:0] ref_rk128(input logic [127:0] k0, input int n);
        logic [127:0] k = k0;
        for (int r = 1; r <= n; r++) begin
            k = (k << 61) | (k >> 67);
            k[127:124] = SBOX_TB[k[127:124]];
            k[123:120] = SBOX_TB[k[123:120]];
            k[66:62]   = k[66:62] ^ 5'(r);
        end
        return k[127:64];
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check(input string name, input int u, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s (inst %0d): got %0h, required %0h", name, u, got, exp);
        end
    endtask

    task automatic check_both(input string name, input logic [127:0] g80, input logic [127:0] g128,
                              input logic [127:0] exp);
        check(name, 0, g80, exp);
        check(name, 1, g128, exp);
    endtask

    task automatic check_idle_zero(input string tag);
        check_both({tag, "_rk_valid"}, 128'(valid80), 128'(valid128), 128'(0));
        check_both({tag, "_busy"},     128'(busy80),  128'(busy128),  128'(0));
        check_both({tag, "_rk_data"},  128'(data80),  128'(data128),  128'(0));
        check_both({tag, "_rk_index"}, 128'(index80), 128'(index128), 128'(0));
        check_both({tag, "_done"},     128'(done80),  128'(done128),  128'(0));
    endtask

    task automatic flush();
        q80.delete();
        q128.delete();
    endtask

    // Monitor for one instance: pops on each accepted transfer, checks stall stability and done.
    task automatic mon(input int u, input logic v, input logic [63:0] d, input logic [4:0] ix, input logic dn);
        exp_t e;
        bit have;
        if (rst) begin
            prev_stall[u] = 1'b0;
            return;
        end
        if (v && prev_stall[u]) begin
            check("stall_rk_data", u, 128'(d), 128'(prev_data[u]));
            check("stall_rk_index", u, 128'(ix), 128'(prev_idx[u]));
        end
        if (v && rk_ready && !abort) begin
            have = 1'b0;
            if (u == 0 && q80.size() > 0) begin
                e = q80.pop_front();
                have = 1'b1;
            end else if (u == 1 && q128.size() > 0) begin
                e = q128.pop_front();
                have = 1'b1;
            end
            if (!have) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_key (inst %0d): got index %0d data %h, required no transfer", u, ix, d);
            end else begin
                check("rk_data", u, 128'(d), 128'(e.data));
                check("rk_index", u, 128'(ix), 128'(e.idx));
            end
            last_idx[u] = int'(ix);
        end
        prev_stall[u] = v && !rk_ready;
        prev_data[u]  = d;
        prev_idx[u]   = ix;
        if (dn) begin
            done_seen[u]++;
            check("done_after_K32", u, 128'(last_idx[u]), 128'(NR));
            last_idx[u] = -1;
        end
    endtask

    always @(negedge clk) begin
        mon(0, valid80, data80, index80, done80);
        mon(1, valid128, data128, index128, done128);
    end

    // One schedule, entered at #1 after a rising edge. Optional abort/reset/start-glitch/latency checks.
    task automatic run(input logic [127:0] k, input int ready_pct, input int abort_at, input int rst_at,
                       input bit glitch, input bit latency, input bit with_abort, input bit zero_consts);
        exp_t e;
        int   accepted, guard, edges, first_done, n;
        bit   ready;
        for (int i = 0; i < NKEYS; i++) begin
            e.idx  = 5'(i);
            e.data = (zero_consts && i < 3) ? ZK80[i] : ref_rk80(k[79:0], i);
            q80.push_back(e);
            e.data = ref_rk128(k, i);
            q128.push_back(e);
        end
        start    = 1'b1;
        key_in   = k;
        abort    = with_abort;
        rk_ready = 1'($urandom_range(1));
        @(posedge clk); #1;
        start      = 1'b0;
        abort      = 1'b0;
        accepted   = 0;
        guard      = 0;
        edges      = 0;
        first_done = -1;
        while (accepted < NKEYS && guard < 3000) begin
            ready = ($urandom_range(99) < ready_pct);
            if (accepted == abort_at) begin
                ready = 1'b1;
                abort = 1'b1;
            end
            rk_ready = ready;
            if (glitch && accepted == 7) begin
                start  = 1'b1;
                key_in = ~k;
            end
            if (accepted == rst_at) begin
                #1 rst = 1'b1;
                #1 check_idle_zero("async_rst");
                @(posedge clk); #1;
                rst = 1'b0;
                flush();
                return;
            end
            @(posedge clk); #1;
            guard++;
            edges++;
            if (latency && done80 && first_done < 0) first_done = edges;
            start = 1'b0;
            if (abort) begin
                abort = 1'b0;
                flush();
                check_both("abort_rk_valid", 128'(valid80), 128'(valid128), 128'(0));
                check_both("abort_done", 128'(done80), 128'(done128), 128'(0));
                check_both("abort_rk_data", 128'(data80), 128'(data128), 128'(0));
                @(posedge clk); #1;
                check_both("abort_no_late_done", 128'(done80), 128'(done128), 128'(0));
                return;
            end
            if (ready) accepted++;
        end
        if (guard >= 3000) begin
            n_cmp++;
            n_bad++;
            $display("FAIL transfer_timeout: got %0d accepted, required %0d", accepted, NKEYS);
        end
        n = 0;
        while (!(done80 && done128) && n < 4) begin
            @(posedge clk); #1;
            n++;
            edges++;
            if (latency && done80 && first_done < 0) first_done = edges;
        end
        // Cycle count includes the cycle in which start was asserted.
        if (latency) check("start_to_done_cycles", 0, 128'(first_done + 1), 128'(NR + 2));
        check_both("done_pulse", 128'(done80), 128'(done128), 128'(1));
        exp_done++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, required finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;
        rk_ready = 1'b0;
        key_in   = '0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_zero("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        run(128'd0, 100, -1, -1, 1'b0, 1'b1, 1'b0, 1'b1);
        run(rand128(), 100, -1, -1, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) run(rand128(), 60, -1, -1, 1'b0, 1'b0, 1'b0, 1'b0);
        run(rand128(), 70, -1, -1, 1'b1, 1'b0, 1'b0, 1'b0);
        run(rand128(), 100, 10, -1, 1'b0, 1'b0, 1'b0, 1'b0);
        run(rand128(), 50, -1, 5, 1'b0, 1'b0, 1'b0, 1'b0);
        run(rand128(), 100, -1, -1, 1'b0, 1'b0, 1'b1, 1'b0);
        run(rand128(), 40, -1, -1, 1'b0, 1'b0, 1'b0, 1'b0);

        rk_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("queue_drained", 0, 128'(q80.size()), 128'(0));
        check("queue_drained", 1, 128'(q128.size()), 128'(0));
        check("done_count", 0, 128'(done_seen[0]), 128'(exp_done));
        check("done_count", 1, 128'(done_seen[1]), 128'(exp_done));
        check_both("final_idle_valid", 128'(valid80), 128'(valid128), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
